vga_frame_capture: RTL and testbench

- Receive-side counterpart of the VGA display path: samples an incoming VGA stream (h_sync, v_sync, 8-bit rgb) and writes one window of one frame into the shared 19-bit-addressed frame SRAM.
- Timing matches the display side: syncs are active-high, the window starts 144 pixel ticks after the h_sync rising edge and 35 lines after the v_sync rising edge.
- Software arms it with start; it captures exactly one frame, then reports done.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_sync_tracker.sv | 53 +++++
 rtl/vga_frame_capture.sv | 130 +++++++++++++
 tb/tb_vga_frame_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants, capture FSM state type and SRAM address helpers
// used by the frame-capture path.
package vga_pkg;

    localparam int H_SYNC_LEN = 96;
    localparam int H_START    = 144;
    localparam int H_TOTAL    = 800;
    localparam int V_SYNC_LEN = 2;
    localparam int V_START    = 35;
    localparam int V_TOTAL    = 525;

    localparam int CAP_WIDTH  = 320;
    localparam int CAP_HEIGHT = 320;
    localparam int CAP_BASE   = 204800;

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} cap_state_t;

    typedef logic [18:0] sram_addr_t;

    // base + major*stride + minor evaluated in 32 bits, then cut to the SRAM address width
    function automatic sram_addr_t pixel_addr(input logic [31:0] base,
                                              input logic [31:0] major,
                                              input logic [31:0] minor,
                                              input logic [31:0] stride);
        logic [31:0] full;
        full = base + major * stride + minor;
        return full[18:0];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Sync edge detection and horizontal/vertical position counters for an incoming VGA stream;
// everything advances only on pix_en ticks.
module vga_sync_tracker
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic        tick,
    output logic        h_rise,
    output logic        v_rise,
    output logic [15:0] h_pos,
    output logic [15:0] line
);

    logic        prev_h;
    logic        prev_v;
    logic [15:0] h_pos_q;
    logic [15:0] line_q;

    assign tick   = pix_en;
    assign h_rise = pix_en & h_sync & ~prev_h;
    assign v_rise = pix_en & v_sync & ~prev_v;

    // h_pos/line give the position of the current tick; the _q registers hold the last tick's
    always_comb begin
        h_pos = h_rise ? 16'd0 : sat_inc(h_pos_q);
        if (v_rise) begin
            line = 16'd0;
        end else if (h_rise) begin
            line = sat_inc(line_q);
        end else begin
            line = line_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_h  <= 1'b0;
            prev_v  <= 1'b0;
            h_pos_q <= 16'd0;
            line_q  <= 16'd0;
        end else if (pix_en) begin
            prev_h  <= h_sync;
            prev_v  <= v_sync;
            h_pos_q <= h_pos;
            line_q  <= line;
        end
    end

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one window of one incoming VGA frame into the frame SRAM after a start request.
// Define VGA_CAPTURE_ROTATE_EN for transposed (column-major) SRAM addressing.
module vga_frame_capture
    import vga_pkg::*;
#(
    parameter int H_START   = vga_pkg::H_START,
    parameter int V_START   = vga_pkg::V_START,
    parameter int WIDTH     = vga_pkg::CAP_WIDTH,
    parameter int HEIGHT    = vga_pkg::CAP_HEIGHT,
    parameter int BASE_ADDR = vga_pkg::CAP_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        start,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [7:0]  rgb,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [31:0] H_LO     = 32'(H_START);
    localparam logic [31:0] H_HI     = 32'(H_START + WIDTH);
    localparam logic [31:0] V_LO     = 32'(V_START);
    localparam logic [31:0] V_HI     = 32'(V_START + HEIGHT);
    localparam logic [31:0] LAST_COL = 32'(WIDTH - 1);
    localparam logic [31:0] LAST_ROW = 32'(HEIGHT - 1);

    logic        tick;
    logic        h_rise;
    logic        v_rise;
    logic [15:0] h_pos;
    logic [15:0] line;
    logic [31:0] h_pos32;
    logic [31:0] line32;
    logic [31:0] col;
    logic [31:0] row;
    logic        active;
    logic        last_pixel;
    sram_addr_t  addr;
    cap_state_t  state;

    vga_sync_tracker u_tracker (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .h_sync (h_sync),
        .v_sync (v_sync),
        .tick   (tick),
        .h_rise (h_rise),
        .v_rise (v_rise),
        .h_pos  (h_pos),
        .line   (line)
    );

    // Window test and pixel address for the position of the current tick
    always_comb begin
        h_pos32    = {16'd0, h_pos};
        line32     = {16'd0, line};
        col        = h_pos32 - H_LO;
        row        = line32 - V_LO;
        active     = (h_pos32 >= H_LO) && (h_pos32 < H_HI) &&
                     (line32 >= V_LO) && (line32 < V_HI);
        last_pixel = (row == LAST_ROW) && (col == LAST_COL);
`ifdef VGA_CAPTURE_ROTATE_EN
        addr = pixel_addr(32'(BASE_ADDR), col, row, 32'(HEIGHT));
`else
        addr = pixel_addr(32'(BASE_ADDR), row, col, 32'(WIDTH));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_VS;
                        busy  <= 1'b1;
                    end
                end
                WAIT_VS: begin
                    if (v_rise) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // a new frame starting before the window is complete truncates the capture
                    if (v_rise) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (tick && active) begin
                        wr_en   <= 1'b1;
                        wr_data <= rgb;
                        wr_addr <= addr;
                        if (last_pixel) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a scaled stream (32-tick lines, 12-line frames, 8x6 window)
// so full frames stay short; honours VGA_CAPTURE_ROTATE_EN in its address model.
module tb_vga_frame_capture;

    localparam int H_START     = 20;
    localparam int V_START     = 3;
    localparam int WIDTH       = 8;
    localparam int HEIGHT      = 6;
    localparam int BASE        = 204800;
    localparam int LINE_LEN    = 32;
    localparam int HS_LEN      = 4;
    localparam int FRAME_LINES = 12;
    localparam int VS_LEN      = 2;
    localparam int WINDOW_PIX  = WIDTH * HEIGHT;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        start;
    logic        h_sync;
    logic        v_sync;
    logic [7:0]  rgb;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    typedef struct {
        logic [18:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        int abort_line;
        int gap;
        int exp_writes;
        int exp_done;
        int exp_err;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vecs[6];
    int          checks      = 0;
    int          errors      = 0;
    int          cyc         = 0;
    int          last_wr_cyc = -10;
    int          wr_total    = 0;
    int          done_total  = 0;
    int          err_total   = 0;
    logic [18:0] last_addr   = '0;

    always #5 clk = ~clk;

    vga_frame_capture #(
        .H_START   (H_START),
        .V_START   (V_START),
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .start      (start),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .rgb        (rgb),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Observes the outputs once per clk and pops the scoreboard on every write
    task automatic sample();
        wr_t e;
        cyc++;
        if (wr_en === 1'b1) begin
            wr_total++;
            last_wr_cyc = cyc;
            last_addr   = wr_addr;
            check_output("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("wr_addr", 32'(wr_addr), 32'(e.addr));
                check_output("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
        if (frame_done === 1'b1) begin
            done_total++;
            check_output("done_after_last_wr", 32'(cyc - last_wr_cyc), 32'd1);
        end
        if (frame_err === 1'b1) begin
            err_total++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
    endtask

    // One pixel tick followed by gap idle clocks carrying inverted syncs and junk data
    task automatic drive_tick(input logic hs, input logic vs, input logic [7:0] d, input int gap);
        h_sync = hs;
        v_sync = vs;
        rgb    = d;
        pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
            h_sync = ~hs;
            v_sync = ~vs;
            rgb    = 8'($urandom);
            step();
        end
        h_sync = hs;
        v_sync = vs;
    endtask

    task automatic drive_lines(input bit cap, input int y0, input int y1, input int gap);
        wr_t        e;
        logic [7:0] d;
        for (int y = y0; y < y1; y++) begin
            for (int x = 0; x < LINE_LEN; x++) begin
                d = 8'(x ^ y);
                if (cap && x >= H_START && x < H_START + WIDTH && y >= V_START && y < V_START + HEIGHT) begin
                    e.data = d;
`ifdef VGA_CAPTURE_ROTATE_EN
                    e.addr = 19'(BASE + (x - H_START) * HEIGHT + (y - V_START));
`else
                    e.addr = 19'(BASE + (y - V_START) * WIDTH + (x - H_START));
`endif
                    exp_q.push_back(e);
                end
                drive_tick(x < HS_LEN, y < VS_LEN, d, gap);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int w0;
        int d0;
        int e0;
        vec_t v;

        vecs[0] = '{-1, 1, WINDOW_PIX, 1, 0};
        vecs[1] = '{ 6, 1, 24,         0, 1};
        vecs[2] = '{ 4, 0, 8,          0, 1};
        vecs[3] = '{ 3, 2, 0,          0, 1};
        vecs[4] = '{ 9, 0, WINDOW_PIX, 1, 0};
        vecs[5] = '{-1, 2, WINDOW_PIX, 1, 0};

        rst    = 1'b1;
        pix_en = 1'b0;
        start  = 1'b0;
        h_sync = 1'b0;
        v_sync = 1'b0;
        rgb    = 8'd0;
        repeat (3) step();
        check_output("reset_outputs", 32'({wr_en, wr_addr, wr_data, busy, frame_done, frame_err}), 32'd0);
        rst = 1'b0;
        step();

        w0 = wr_total;
        drive_lines(1'b0, 0, FRAME_LINES, 1);
        check_output("idle_writes", 32'(wr_total - w0), 32'd0);
        check_output("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            v  = vecs[i];
            w0 = wr_total;
            d0 = done_total;
            e0 = err_total;
            pulse_start();
            check_output($sformatf("vec%0d_armed_busy", i), 32'(busy), 32'd1);
            drive_lines(1'b1, 0, (v.abort_line < 0) ? FRAME_LINES : v.abort_line, v.gap);
            drive_lines(1'b0, 0, FRAME_LINES, v.gap);
            check_output($sformatf("vec%0d_writes", i), 32'(wr_total - w0), 32'(v.exp_writes));
            check_output($sformatf("vec%0d_done", i), 32'(done_total - d0), 32'(v.exp_done));
            check_output($sformatf("vec%0d_err", i), 32'(err_total - e0), 32'(v.exp_err));
            check_output($sformatf("vec%0d_busy_end", i), 32'(busy), 32'd0);
            check_output($sformatf("vec%0d_queue_empty", i), 32'(exp_q.size()), 32'd0);
            if (v.exp_done == 1) begin
                check_output($sformatf("vec%0d_last_addr", i), 32'(last_addr), 32'(BASE + WINDOW_PIX - 1));
            end
        end

        // start while capturing must not restart the capture
        w0 = wr_total;
        d0 = done_total;
        pulse_start();
        drive_lines(1'b1, 0, 5, 1);
        pulse_start();
        check_output("restart_busy", 32'(busy), 32'd1);
        drive_lines(1'b1, 5, FRAME_LINES, 1);
        check_output("restart_writes", 32'(wr_total - w0), 32'(WINDOW_PIX));
        check_output("restart_done", 32'(done_total - d0), 32'd1);

        // reset in the middle of the window
        w0 = wr_total;
        d0 = done_total;
        e0 = err_total;
        pulse_start();
        drive_lines(1'b1, 0, 5, 1);
        check_output("pre_reset_writes", 32'(wr_total - w0), 32'(2 * WIDTH));
        rst = 1'b1;
        step();
        check_output("mid_reset_outputs", 32'({wr_en, wr_addr, wr_data, busy, frame_done, frame_err}), 32'd0);
        rst = 1'b0;
        repeat (3) step();
        w0 = wr_total;
        drive_lines(1'b0, 0, FRAME_LINES, 1);
        check_output("post_reset_writes", 32'(wr_total - w0), 32'd0);
        check_output("post_reset_done", 32'(done_total - d0), 32'd0);
        check_output("post_reset_err", 32'(err_total - e0), 32'd0);

        // h_sync and v_sync rising together: line clears instead of advancing to 12
        drive_tick(1'b1, 1'b1, 8'd0, 1);
        check_output("both_edges_line", 32'(dut.u_tracker.line_q), 32'd0);
        check_output("both_edges_hpos", 32'(dut.u_tracker.h_pos_q), 32'd0);

        for (int n = 0; n < 65540; n++) begin
            drive_tick(1'b0, 1'b1, 8'd0, 0);
        end
        check_output("hpos_saturated", 32'(dut.u_tracker.h_pos_q), 32'h0000FFFF);
        check_output("line_held", 32'(dut.u_tracker.line_q), 32'd0);
        check_output("sat_no_writes_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
